// File: rtl/mul4_fitness_eval.sv
// rtl/mul4_fitness_eval.sv - exhaustive-lane scoring harness for 2x2 bit-sliced multiplier candidates
module mul4_fitness_eval #(
  parameter int LATENCY = 1,
  parameter int ID_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [ID_W-1:0] cand_id,
  output logic [15:0]     a1,
  output logic [15:0]     a0,
  output logic [15:0]     b1,
  output logic [15:0]     b0,
  input  logic [15:0]     y3,
  input  logic [15:0]     y2,
  input  logic [15:0]     y1,
  input  logic [15:0]     y0,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [6:0]      score,
  output logic [15:0]     err3,
  output logic [15:0]     err2,
  output logic [15:0]     err1,
  output logic [15:0]     err0,
  output logic            perfect,
  output logic [6:0]      best_score,
  output logic [ID_W-1:0] best_id,
  input  logic            clr_best
);

  // Lane i carries a = i[3:2], b = i[1:0]; these vectors enumerate all 16 operand pairs.
  localparam logic [15:0] OP_A1 = 16'hFF00;
  localparam logic [15:0] OP_A0 = 16'hF0F0;
  localparam logic [15:0] OP_B1 = 16'hCCCC;
  localparam logic [15:0] OP_B0 = 16'hAAAA;

  // Reference product bits for the same 16 lanes.
  localparam logic [15:0] GOLD_3 = 16'h8000;
  localparam logic [15:0] GOLD_2 = 16'h4C00;
  localparam logic [15:0] GOLD_1 = 16'h6AC0;
  localparam logic [15:0] GOLD_0 = 16'hA0A0;

  localparam logic [3:0] SETTLE_LOAD = 4'(LATENCY);
  localparam logic [6:0] FULL_SCORE  = 7'd64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      settle_cnt;
  logic [1:0]      word_idx;
  logic [6:0]      acc;
  logic [ID_W-1:0] id_q;

  logic [15:0]     err_word;
  logic [4:0]      word_ones;
  logic [6:0]      acc_next;
  logic            accept;
  logic            sample;
  logic            last_word;

  function automatic logic [4:0] popcount16(input logic [15:0] w);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'b0000, w[i]};
    end
    return c;
  endfunction

  // Next-state decode plus the state-derived handshake and operand outputs
  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    a1          = '0;
    a0          = '0;
    b1          = '0;
    b0          = '0;
    accept      = 1'b0;
    sample      = 1'b0;
    last_word   = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          accept  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        a1 = OP_A1;
        a0 = OP_A0;
        b1 = OP_B1;
        b0 = OP_B0;
        // The counter hits zero on this edge, so y has had LATENCY edges to settle.
        if (settle_cnt <= 4'd1) begin
          sample  = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (word_idx == 2'd3) begin
          last_word = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select this COUNT cycle's mismatch word and charge its ones against the accumulator
  always_comb begin
    case (word_idx)
      2'd0:    err_word = err0;
      2'd1:    err_word = err1;
      2'd2:    err_word = err2;
      default: err_word = err3;
    endcase
    word_ones = popcount16(err_word);
    acc_next  = acc - {2'b00, word_ones};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Evaluation datapath: settle timer, sampled error masks, score accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      word_idx   <= '0;
      acc        <= '0;
      id_q       <= '0;
      err3       <= '0;
      err2       <= '0;
      err1       <= '0;
      err0       <= '0;
      score      <= '0;
    end else begin
      if (accept) begin
        id_q       <= cand_id;
        settle_cnt <= SETTLE_LOAD;
      end
      if (state_q == SETTLE) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (sample) begin
        err3     <= y3 ^ GOLD_3;
        err2     <= y2 ^ GOLD_2;
        err1     <= y1 ^ GOLD_1;
        err0     <= y0 ^ GOLD_0;
        acc      <= FULL_SCORE;
        word_idx <= '0;
      end
      if (state_q == COUNT) begin
        word_idx <= word_idx + 2'd1;
        acc      <= acc_next;
      end
      if (last_word) begin
        score <= acc_next;
      end
    end
  end

  // Best-candidate tracker; a clear on the same edge as an update takes priority
  always_ff @(posedge clk) begin
    if (!rst_n || clr_best) begin
      best_score <= '0;
      best_id    <= '0;
    end else if (last_word && (acc_next > best_score)) begin
      best_score <= acc_next;
      best_id    <= id_q;
    end
  end

  assign perfect = (score == FULL_SCORE);

endmodule

// File: tb/tb_mul4_fitness_eval.sv
// tb/tb_mul4_fitness_eval.sv - randomized self-checking bench for mul4_fitness_eval
module tb_mul4_fitness_eval;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic        start_valid = 1'b0;
  logic        res_ready   = 1'b0;
  logic        clr_best    = 1'b0;
  logic [7:0]  cand_id     = 8'h00;
  int          mode        = 0;
  logic [15:0] ry [4];

  logic [15:0] op1 [4];
  logic [15:0] op3 [4];
  logic [15:0] yv1 [4];
  logic [15:0] yv3 [4];
  logic [15:0] e1  [4];
  logic [15:0] e3  [4];
  logic [15:0] pr1 [4];
  logic [15:0] pr3 [4];
  logic        sr1, sr3, rv1, rv3, pf1, pf3;
  logic [6:0]  sc1, sc3, bs1, bs3;
  logic [7:0]  bi1, bi3;

  int          checks = 0;
  int          errors = 0;
  int          mbs1   = 0;
  int          mbs3   = 0;
  logic [7:0]  mbi1   = 8'h00;
  logic [7:0]  mbi3   = 8'h00;

  always #5 clk = ~clk;

  // Product bit k of lane i, where lane i means a = i/4, b = i%4
  function automatic logic [15:0] gold(input int k);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = 1'((((i / 4) * (i % 4)) >> k) & 1);
    return w;
  endfunction

  // Lane-wise multiply of whatever operands the harness presents
  function automatic logic [15:0] mulw(input logic [15:0] xa1, xa0, xb1, xb0, input int k);
    logic [15:0] w;
    int a, b;
    for (int i = 0; i < 16; i++) begin
      a = 2 * int'(xa1[i]) + int'(xa0[i]);
      b = 2 * int'(xb1[i]) + int'(xb0[i]);
      w[i] = 1'(((a * b) >> k) & 1);
    end
    return w;
  endfunction

  // What the candidate presents at the sample edge for a given mode and settle latency
  function automatic logic [15:0] cand_y(input int m, input int k, input int lat);
    case (m)
      0:       return gold(k);
      1:       return 16'h0000;
      2:       return 16'hFFFF;
      3:       return ry[k];
      default: return (lat == 1) ? 16'h0000 : gold(k);
    endcase
  endfunction

  function automatic int exp_score(input int m, input int lat);
    int s;
    s = 64;
    for (int k = 0; k < 4; k++) s = s - $countones(cand_y(m, k, lat) ^ gold(k));
    return s;
  endfunction

  // Candidate netlists: combinational modes plus a one-register pipelined multiplier
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      yv1[k] = (mode == 4) ? pr1[k] : cand_y(mode, k, 1);
      yv3[k] = (mode == 4) ? pr3[k] : cand_y(mode, k, 3);
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      pr1[k] <= rst_n ? mulw(op1[0], op1[1], op1[2], op1[3], k) : 16'h0000;
      pr3[k] <= rst_n ? mulw(op3[0], op3[1], op3[2], op3[3], k) : 16'h0000;
    end
  end

  mul4_fitness_eval #(.LATENCY(1), .ID_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr1), .cand_id(cand_id),
    .a1(op1[0]), .a0(op1[1]), .b1(op1[2]), .b0(op1[3]),
    .y3(yv1[3]), .y2(yv1[2]), .y1(yv1[1]), .y0(yv1[0]),
    .res_valid(rv1), .res_ready(res_ready), .score(sc1),
    .err3(e1[3]), .err2(e1[2]), .err1(e1[1]), .err0(e1[0]),
    .perfect(pf1), .best_score(bs1), .best_id(bi1), .clr_best(clr_best)
  );

  mul4_fitness_eval #(.LATENCY(3), .ID_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr3), .cand_id(cand_id),
    .a1(op3[0]), .a0(op3[1]), .b1(op3[2]), .b0(op3[3]),
    .y3(yv3[3]), .y2(yv3[2]), .y1(yv3[1]), .y0(yv3[0]),
    .res_valid(rv3), .res_ready(res_ready), .score(sc3),
    .err3(e3[3]), .err2(e3[2]), .err1(e3[1]), .err0(e3[0]),
    .perfect(pf3), .best_score(bs3), .best_id(bi3), .clr_best(clr_best)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_ready1", sr1, 1);
    check("rst_ready3", sr3, 1);
    check("rst_ops1", {op1[0], op1[1], op1[2], op1[3]}, 0);
    check("rst_ops3", {op3[0], op3[1], op3[2], op3[3]}, 0);
    check("rst_valid", {rv1, rv3, pf1, pf3}, 0);
    check("rst_score", {sc1, sc3}, 0);
    check("rst_err1", {e1[3], e1[2], e1[1], e1[0]}, 0);
    check("rst_err3", {e3[3], e3[2], e3[1], e3[0]}, 0);
    check("rst_best", {bs1, bi1, bs3, bi3}, 0);
    mbs1 = 0; mbi1 = 8'h00; mbs3 = 0; mbi3 = 8'h00;
  endtask

  // One evaluation on both harnesses; the result is held under backpressure before release
  task automatic eval(input int m, input logic [7:0] id, input bit clr_final);
    int s1, s3, l1, l3;
    logic [6:0] hold1;
    @(negedge clk);
    mode = m;
    for (int k = 0; k < 4; k++) ry[k] = 16'($urandom);
    s1 = exp_score(m, 1);
    s3 = exp_score(m, 3);
    l1 = -1; l3 = -1; hold1 = '0;
    check("start_ready_idle", {sr1, sr3}, 2'b11);
    start_valid = 1'b1;
    cand_id     = id;
    @(posedge clk);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      start_valid = (n >= 1 && n <= 9);
      clr_best    = clr_final && (n == 4);
      if (n == 0) begin
        check("ops_settle1", {op1[0], op1[1], op1[2], op1[3]}, 64'hFF00F0F0CCCCAAAA);
        check("ops_settle3", {op3[0], op3[1], op3[2], op3[3]}, 64'hFF00F0F0CCCCAAAA);
        check("busy_ready0", {sr1, sr3}, 0);
      end
      if (n == 5) hold1 = sc1;
      if (n == 9) check("bp_ready", {sr1, sr3}, 0);
      if (l1 < 0 && rv1) l1 = n;
      if (l3 < 0 && rv3) l3 = n;
    end
    start_valid = 1'b0;
    check("ops_done", {op1[0], op1[1], op1[2], op1[3], op3[0]}, 0);
    check("latency1", l1, 5);
    check("latency3", l3, 7);
    check("valid_held", {rv1, rv3}, 2'b11);
    check("score1", sc1, s1);
    check("score_stable1", sc1, hold1);
    check("score3", sc3, s3);
    check("perfect", {pf1, pf3}, {s1 == 64, s3 == 64});
    for (int k = 0; k < 4; k++) begin
      check($sformatf("err%0d_lat1", k), e1[k], cand_y(m, k, 1) ^ gold(k));
      check($sformatf("err%0d_lat3", k), e3[k], cand_y(m, k, 3) ^ gold(k));
    end
    if (clr_final) begin
      mbs1 = 0; mbi1 = 8'h00; mbs3 = 0; mbi3 = 8'h00;
    end else if (s1 > mbs1) begin
      mbs1 = s1; mbi1 = id;
    end
    if (s3 > mbs3) begin
      mbs3 = s3; mbi3 = id;
    end
    check("best1", {bs1, bi1}, {7'(mbs1), mbi1});
    check("best3", {bs3, bi3}, {7'(mbs3), mbi3});
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("release", {sr1, rv1, sr3, rv3}, 4'b1010);
  endtask

  // Start an evaluation, then reset it on edge T+rn
  task automatic abort_eval(input int rn);
    @(negedge clk);
    mode        = 0;
    start_valid = 1'b1;
    cand_id     = 8'h55;
    @(posedge clk);
    for (int n = 0; n < rn; n++) begin
      @(negedge clk);
      start_valid = 1'b0;
      if (n == rn - 1) rst_n = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) ry[k] = 16'h0000;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset();
    rst_n = 1'b1;

    eval(0, 8'd10, 1'b0);
    check("golden_score", sc1, 64);
    eval(1, 8'd11, 1'b0);
    check("zeros_score", sc1, 50);
    check("zeros_err", {e1[3], e1[2], e1[1], e1[0]}, 64'h80004C006AC0A0A0);
    eval(2, 8'd12, 1'b0);
    check("ones_score", sc1, 14);
    eval(4, 8'd13, 1'b0);
    check("pipe_scores", {sc1, sc3}, {7'd50, 7'd64});

    @(negedge clk);
    clr_best = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_best = 1'b0;
    mbs1 = 0; mbi1 = 8'h00; mbs3 = 0; mbi3 = 8'h00;
    check("clr_idle", {bs1, bi1, bs3, bi3}, 0);

    eval(1, 8'd1, 1'b0);
    eval(0, 8'd2, 1'b0);
    eval(0, 8'd3, 1'b0);
    check("best_seq", {bs1, bi1}, {7'd64, 8'd2});
    eval(0, 8'd4, 1'b1);
    check("clr_wins", {bs1, bi1}, 0);

    for (int r = 0; r < 4; r++) eval(3, 8'($urandom), 1'b0);

    abort_eval(1);
    abort_eval(3);
    eval(3, 8'h77, 1'b0);
    eval(0, 8'h78, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul4_fitness_eval.md
# mul4_fitness_eval

Sequential scoring harness for evolved 2-bit x 2-bit bit-sliced multiplier candidates. It drives the exhaustive 16-lane operand set onto a candidate's a1/a0/b1/b0 inputs and samples the candidate's y3..y0 after a configurable settle time. It compares the samples against the golden product, reports a 0..64 bit-match score with per-output error masks, and tracks the best candidate since the last clear. It sits between the candidate-swap controller (start/result handshake) and the candidate netlist under evaluation.

## Interface
- LATENCY, default 1, edges from operand drive to sampling of y; legal range 1..15
- ID_W, default 8, width of candidate identifier
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start_valid  in  1  request evaluation of the currently attached candidate
- start_ready  out  1  high only in IDLE
- cand_id  in  ID_W  candidate identifier, captured on start handshake
- a1, a0, b1, b0  out  16 each  operand vectors to candidate
- y3, y2, y1, y0  in  16 each  candidate outputs
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- score  out  7  matching bits, 0..64
- err3, err2, err1, err0  out  16 each  per-lane mismatch masks (y XOR golden)
- perfect  out  1  score == 64
- best_score  out  7  highest score since reset/clear
- best_id  out  ID_W  cand_id that produced best_score
- clr_best  in  1  zero best_score/best_id

## Operation
- Lane i (0..15) encodes a = i[3:2], b = i[1:0]. Operand constants while driving: a1=16'hFF00, a0=16'hF0F0, b1=16'hCCCC, b0=16'hAAAA. All four are 16'h0000 in IDLE and DONE.
- Golden product: g3=16'h8000, g2=16'h4C00, g1=16'h6AC0, g0=16'hA0A0 (14 ones total).
- IDLE: start_ready=1. A handshake captures cand_id and moves to SETTLE, with the settle counter loaded to LATENCY.
- SETTLE: operands driven. The counter decrements each edge. When it reaches 0, y3..y0 are registered, err masks = y XOR g are registered, and the FSM moves to COUNT.
- COUNT: 4 cycles. One err word per cycle, order err0, err1, err2, err3. The word's popcount is subtracted from an accumulator preset to 64. Operands return to 0 on entering COUNT.
- The final COUNT edge writes score, sets res_valid and enters DONE. The best update happens on this same edge: if score > best_score (strict; ties keep the earlier id), then best_score <= score and best_id <= captured id.
- DONE: res_valid=1; score, err*, perfect held stable. When res_valid && res_ready, return to IDLE. res_valid stays high for the whole DONE state, including any backpressure.
- clr_best: zeros best_score and best_id on that edge. If it coincides with a best update, clear wins.
- Score arithmetic is 7-bit unsigned with no overflow possible. The popcount is combinational per 16-bit word, 5-bit result.

## Timing
- Reset (rst_n=0 at an edge) puts the FSM in IDLE and forces every output to 0 except start_ready=1: operands, res_valid, score, err*, perfect, best_score, best_id. This applies from any state, mid-evaluation included. Any in-flight evaluation is discarded.
- Start handshake at edge T: operands valid from T until y is sampled at edge T+LATENCY. res_valid is high after edge T+LATENCY+4. Total latency is LATENCY+4 edges.
- start_ready is low from T until the edge after the result handshake. Minimum spacing between start accepts is LATENCY+6 edges.
- start_valid outside IDLE is ignored, not queued.
- Candidate inputs y* are only observed on the sample edge. Activity at other times has no effect.

## Test plan
- Golden candidate (y* tied to g*), LATENCY=1: start at T -> res_valid after edge T+5, score=64, err*=0, perfect=1.
- Candidate outputs all 0 -> score=50, err3=16'h8000, err2=16'h4C00, err1=16'h6AC0, err0=16'hA0A0, perfect=0. Outputs all 1 -> score=14.
- LATENCY=3 with a one-register-pipelined golden candidate -> score=64. The same candidate at LATENCY=1 -> score=50, because it samples the reset-zero register.
- Backpressure: res_ready low 5 cycles after res_valid. Score and err stay stable, start_ready=0, and start_valid pulses are ignored. The IDLE return happens one edge after res_ready=1.
- Best tracking: evaluate ids 1, 2, 3 with scores 50, 64, 64 -> best_score=64, best_id=2. Then clr_best coinciding with the next final COUNT edge -> best_score=0, best_id=0.
- Reset during SETTLE and during COUNT: all outputs at reset values on the next cycle. The next start evaluates normally with no residue from the prior accumulator.
